// File: rtl/oric_sdram_sched.sv
// Oric SDRAM port1 scheduler: arbitrates ROM download, ROM/Microdisk fetch and CPU RAM over one toggle req/ack port.
// Optional ORIC_SCHED_TMO_EN adds an ack timeout (TMO_CYC cycles) with sticky tmo_err_o.
module oric_sdram_sched #(
    parameter int   TMO_CYC  = 64,
    parameter logic RAM_BASE = 1'b1
) (
    input  logic        clk_i,
    input  logic        res_n_i,
    input  logic        dl_active_i,
    input  logic        dl_wr_i,
    input  logic [16:0] dl_addr_i,
    input  logic [7:0]  dl_data_i,
    input  logic        ram_cs_i,
    input  logic        ram_oe_i,
    input  logic        ram_we_i,
    input  logic [15:0] ram_addr_i,
    input  logic [7:0]  ram_din_i,
    input  logic        rom_cs_i,
    input  logic        rom_ext_cs_i,
    input  logic        rom_sel_i,
    input  logic [13:0] rom_addr_i,
    output logic [7:0]  rd_data_o,
    output logic        busy_o,
    output logic        dl_ovf_o,
    output logic        port_req_o,
    input  logic        port_ack_i,
    output logic [15:0] port_a_o,
    output logic [1:0]  port_ds_o,
    output logic        port_we_o,
    output logic [15:0] port_d_o,
    input  logic [15:0] port_q_i,
    output logic        tmo_err_o
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    state_t state_q, state_d;

    logic        ram_rd_prev_q, ram_wr_prev_q, rom_cs_prev_q, rom_ext_prev_q, dl_active_prev_q;
    logic [15:0] ram_addr_prev_q;
    logic [13:0] rom_addr_prev_q;

    logic        dl_pend_q, ram_pend_q, rom_pend_q, ram_we_s_q;
    logic [16:0] dl_addr_s_q, rom_addr_s_q;
    logic [15:0] ram_addr_s_q;
    logic [7:0]  dl_data_s_q, ram_din_s_q;

    logic [15:0] port_a_q, port_d_q;
    logic [1:0]  port_ds_q;
    logic        port_we_q, port_req_q, cur_rd_q, cur_lsb_q, dl_ovf_q;
    logic [7:0]  rd_data_q;

    logic        ram_rd, ram_wr, ram_ev, rom_ev, dl_flush;
    logic [16:0] rom_byte;
    logic        is_issue, gnt_dl, gnt_ramw, gnt_rom, gnt_ramr, gnt_ram, any_gnt, any_pend;
    logic [16:0] sel_addr;
    logic [7:0]  sel_data;
    logic        sel_we, ack_match, tmo_hit, tmo_abort;

    assign ram_rd   = ram_cs_i & ram_oe_i;
    assign ram_wr   = ram_cs_i & ram_we_i;
    assign ram_ev   = ~dl_active_i & ((ram_wr & ~ram_wr_prev_q) |
                      (ram_rd & (~ram_rd_prev_q | (ram_addr_i != ram_addr_prev_q))));
    assign rom_ev   = ~dl_active_i & ((rom_cs_i & ~rom_cs_prev_q) | (rom_ext_cs_i & ~rom_ext_prev_q) |
                      ((rom_cs_i | rom_ext_cs_i) & (rom_addr_i != rom_addr_prev_q)));
    assign rom_byte = rom_cs_i ? {2'b00, rom_sel_i, rom_addr_i} : {4'b0100, rom_addr_i[12:0]};
    assign dl_flush = dl_active_i & ~dl_active_prev_q;

    // Grant happens only in ISSUE; priority DL > RAM write > ROM > RAM read.
    assign is_issue = (state_q == S_ISSUE);
    assign gnt_dl   = is_issue & dl_pend_q;
    assign gnt_ramw = is_issue & ~dl_pend_q & ram_pend_q & ram_we_s_q;
    assign gnt_rom  = is_issue & ~dl_pend_q & ~(ram_pend_q & ram_we_s_q) & rom_pend_q;
    assign gnt_ramr = is_issue & ~dl_pend_q & ~rom_pend_q & ram_pend_q & ~ram_we_s_q;
    assign gnt_ram  = gnt_ramw | gnt_ramr;
    assign any_gnt  = gnt_dl | gnt_ram | gnt_rom;
    assign any_pend = dl_pend_q | ram_pend_q | rom_pend_q;
    assign ack_match = (port_ack_i == port_req_q);

    always_comb begin
        sel_addr = rom_addr_s_q;
        sel_data = 8'h00;
        sel_we   = 1'b0;
        if (gnt_dl) begin
            sel_addr = dl_addr_s_q;
            sel_data = dl_data_s_q;
            sel_we   = 1'b1;
        end else if (gnt_ram) begin
            sel_addr = {RAM_BASE, ram_addr_s_q};
            sel_data = ram_din_s_q;
            sel_we   = ram_we_s_q;
        end
    end

`ifdef ORIC_SCHED_TMO_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             tmo_err_q;
    assign tmo_hit   = (tmo_cnt_q == TMO_W'(TMO_CYC - 1));
    assign tmo_err_o = tmo_err_q;

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            if (state_q == S_WAIT) tmo_cnt_q <= tmo_cnt_q + 1'b1;
            else                   tmo_cnt_q <= '0;
            if (tmo_abort) tmo_err_q <= 1'b1;
        end
    end
`else
    logic tmo_cfg_unused;
    assign tmo_cfg_unused = (TMO_CYC != 0);
    assign tmo_hit   = 1'b0;
    assign tmo_err_o = 1'b0;
`endif
    assign tmo_abort = (state_q == S_WAIT) & ~ack_match & tmo_hit;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_pend) state_d = S_ISSUE;
            S_ISSUE: state_d = any_gnt ? S_WAIT : S_IDLE;
            S_WAIT:  if (ack_match) state_d = S_DONE;
                     else if (tmo_hit) state_d = S_IDLE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            ram_rd_prev_q <= 1'b0; ram_wr_prev_q <= 1'b0; ram_addr_prev_q <= '0;
            rom_cs_prev_q <= 1'b0; rom_ext_prev_q <= 1'b0; rom_addr_prev_q <= '0;
            dl_active_prev_q <= 1'b0;
            dl_pend_q <= 1'b0; dl_addr_s_q <= '0; dl_data_s_q <= '0; dl_ovf_q <= 1'b0;
            ram_pend_q <= 1'b0; ram_we_s_q <= 1'b0; ram_addr_s_q <= '0; ram_din_s_q <= '0;
            rom_pend_q <= 1'b0; rom_addr_s_q <= '0;
            port_a_q <= '0; port_d_q <= '0; port_ds_q <= '0; port_we_q <= 1'b0; port_req_q <= 1'b0;
            cur_rd_q <= 1'b0; cur_lsb_q <= 1'b0; rd_data_q <= '0;
        end else begin
            ram_rd_prev_q <= ram_rd; ram_wr_prev_q <= ram_wr; ram_addr_prev_q <= ram_addr_i;
            rom_cs_prev_q <= rom_cs_i; rom_ext_prev_q <= rom_ext_cs_i; rom_addr_prev_q <= rom_addr_i;
            dl_active_prev_q <= dl_active_i;

            // A grant in the same cycle frees the slot, so a coincident strobe refills it.
            if (dl_wr_i) begin
                if (dl_pend_q && !gnt_dl) begin
                    dl_ovf_q <= 1'b1;
                end else begin
                    dl_pend_q <= 1'b1; dl_addr_s_q <= dl_addr_i; dl_data_s_q <= dl_data_i;
                end
            end else if (gnt_dl) begin
                dl_pend_q <= 1'b0;
            end

            if (dl_flush)     ram_pend_q <= 1'b0;
            else if (ram_ev) begin
                ram_pend_q <= 1'b1; ram_we_s_q <= ram_wr & ~ram_wr_prev_q;
                ram_addr_s_q <= ram_addr_i; ram_din_s_q <= ram_din_i;
            end else if (gnt_ram) ram_pend_q <= 1'b0;

            if (dl_flush)     rom_pend_q <= 1'b0;
            else if (rom_ev) begin
                rom_pend_q <= 1'b1; rom_addr_s_q <= rom_byte;
            end else if (gnt_rom) rom_pend_q <= 1'b0;

            if (any_gnt) begin
                port_a_q   <= sel_addr[16:1];
                port_ds_q  <= sel_we ? (sel_addr[0] ? 2'b10 : 2'b01) : 2'b11;
                port_we_q  <= sel_we;
                port_d_q   <= {sel_data, sel_data};
                port_req_q <= ~port_req_q;
                cur_rd_q   <= ~sel_we;
                cur_lsb_q  <= sel_addr[0];
            end else if (tmo_abort) begin
                port_req_q <= port_ack_i;
            end

            if (state_q == S_DONE && cur_rd_q)
                rd_data_q <= cur_lsb_q ? port_q_i[15:8] : port_q_i[7:0];
        end
    end

    assign busy_o     = (state_q != S_IDLE) | any_pend;
    assign rd_data_o  = rd_data_q;
    assign dl_ovf_o   = dl_ovf_q;
    assign port_req_o = port_req_q;
    assign port_a_o   = port_a_q;
    assign port_ds_o  = port_ds_q;
    assign port_we_o  = port_we_q;
    assign port_d_o   = port_d_q;
endmodule

// File: tb/tb_oric_sdram_sched.sv
// Directed bench for oric_sdram_sched with a toggle-ack SDRAM model and an issue log.
module tb_oric_sdram_sched;
    logic        clk = 1'b0, res_n = 1'b0;
    logic        dl_active = 0, dl_wr = 0, ram_cs = 0, ram_oe = 0, ram_we = 0;
    logic        rom_cs = 0, rom_ext_cs = 0, rom_sel = 0;
    logic [16:0] dl_addr = '0;
    logic [7:0]  dl_data = '0, ram_din = '0;
    logic [15:0] ram_addr = '0, port_q = '0;
    logic [13:0] rom_addr = '0;
    logic [7:0]  rd_data;
    logic        busy, dl_ovf, port_req, port_ack, port_we, tmo_err;
    logic [15:0] port_a, port_d;
    logic [1:0]  port_ds;

    int n_cmp = 0, n_bad = 0;

    oric_sdram_sched dut (
        .clk_i(clk), .res_n_i(res_n), .dl_active_i(dl_active), .dl_wr_i(dl_wr),
        .dl_addr_i(dl_addr), .dl_data_i(dl_data), .ram_cs_i(ram_cs), .ram_oe_i(ram_oe),
        .ram_we_i(ram_we), .ram_addr_i(ram_addr), .ram_din_i(ram_din), .rom_cs_i(rom_cs),
        .rom_ext_cs_i(rom_ext_cs), .rom_sel_i(rom_sel), .rom_addr_i(rom_addr),
        .rd_data_o(rd_data), .busy_o(busy), .dl_ovf_o(dl_ovf), .port_req_o(port_req),
        .port_ack_i(port_ack), .port_a_o(port_a), .port_ds_o(port_ds), .port_we_o(port_we),
        .port_d_o(port_d), .port_q_i(port_q), .tmo_err_o(tmo_err)
    );

    always #5 clk = ~clk;

    // SDRAM model: acks a toggled request ack_dly cycles later unless held off.
    int ack_dly = 2, ack_cnt = 0;
    bit ack_hold = 0;
    always @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            port_ack <= 1'b0; ack_cnt <= 0;
        end else if (port_req != port_ack && !ack_hold) begin
            if (ack_cnt >= ack_dly) begin port_ack <= port_req; ack_cnt <= 0; end
            else ack_cnt <= ack_cnt + 1;
        end else ack_cnt <= 0;
    end

    // Issue log, sampled with pre-edge values so it never races the checker at negedge.
    logic [15:0] iss_a [0:31];
    logic [15:0] iss_d [0:31];
    logic [1:0]  iss_ds[0:31];
    logic        iss_we[0:31];
    int          n_iss = 0;
    logic        req_seen = 1'b0;
    always @(posedge clk) begin
        if (res_n && port_req != req_seen) begin
            req_seen <= port_req;
            iss_a[n_iss[4:0]] <= port_a; iss_d[n_iss[4:0]] <= port_d;
            iss_ds[n_iss[4:0]] <= port_ds; iss_we[n_iss[4:0]] <= port_we;
            n_iss <= n_iss + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 300) begin @(negedge clk); k++; end
        repeat (2) @(negedge clk);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_iss(input string tag, input int idx, input logic [15:0] a, input logic [1:0] ds,
                           input logic we);
        chk({tag, "_a"},  {16'd0, iss_a[idx[4:0]]}, {16'd0, a});
        chk({tag, "_ds"}, {30'd0, iss_ds[idx[4:0]]}, {30'd0, ds});
        chk({tag, "_we"}, {31'd0, iss_we[idx[4:0]]}, {31'd0, we});
    endtask

    int base;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_req",  {31'd0, port_req}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_rd",   {24'd0, rd_data}, 0);
        chk("rst_a",    {16'd0, port_a}, 0);
        chk("rst_ovf",  {31'd0, dl_ovf}, 0);
        chk("rst_tmo",  {31'd0, tmo_err}, 0);
        res_n = 1'b1;
        @(negedge clk);

        // 1: single download write at odd byte
        dl_active = 1'b1;
        @(negedge clk);
        dl_wr = 1; dl_addr = 17'h00005; dl_data = 8'hA5;
        @(negedge clk); dl_wr = 0;
        wait_idle("t1");
        chk("t1_niss", n_iss, 1);
        chk_iss("t1", 0, 16'h0002, 2'b10, 1'b1);
        chk("t1_d", {16'd0, iss_d[0]}, 32'h0000A5A5);
        chk("t1_req", {31'd0, port_req}, 1);

        // 2: second write refills the slot at grant, third overflows
        ack_dly = 10; base = n_iss;
        dl_wr = 1; dl_addr = 17'h00010; dl_data = 8'h11;
        @(negedge clk); dl_wr = 0;
        @(negedge clk); dl_wr = 1; dl_addr = 17'h00021; dl_data = 8'h22;
        @(negedge clk); dl_wr = 0;
        @(negedge clk); dl_wr = 1; dl_addr = 17'h00030; dl_data = 8'h33;
        @(negedge clk); dl_wr = 0;
        @(negedge clk);
        chk("t2_ovf", {31'd0, dl_ovf}, 1);
        wait_idle("t2");
        chk("t2_niss", n_iss - base, 2);
        chk_iss("t2_w0", base, 16'h0008, 2'b01, 1'b1);
        chk_iss("t2_w1", base + 1, 16'h0010, 2'b10, 1'b1);
        chk("t2_d1", {16'd0, iss_d[base + 1]}, 32'h00002222);
        ack_dly = 2;

        // dl_active blocks CPU requests
        base = n_iss;
        ram_cs = 1; ram_oe = 1; ram_addr = 16'h0200;
        repeat (8) @(negedge clk);
        chk("dla_busy", {31'd0, busy}, 0);
        chk("dla_niss", n_iss - base, 0);
        ram_cs = 0; ram_oe = 0;
        @(negedge clk); dl_active = 0;
        @(negedge clk);

        // 3: RAM read
        base = n_iss; port_q = 16'hBEEF;
        ram_cs = 1; ram_oe = 1; ram_addr = 16'h1234;
        @(negedge clk);
        wait_idle("t3");
        chk_iss("t3", base, 16'h891A, 2'b11, 1'b0);
        chk("t3_rd", {24'd0, rd_data}, 32'hEF);
        ram_cs = 0; ram_oe = 0;
        @(negedge clk);

        // 4: RAM write beats a simultaneous ROM read
        base = n_iss; port_q = 16'hC3D4;
        rom_cs = 1; rom_sel = 1; rom_addr = 14'h3FFF;
        ram_cs = 1; ram_we = 1; ram_addr = 16'h0042; ram_din = 8'h5A;
        @(negedge clk);
        wait_idle("t4");
        chk("t4_niss", n_iss - base, 2);
        chk_iss("t4_w", base, 16'h8021, 2'b01, 1'b1);
        chk("t4_d", {16'd0, iss_d[base]}, 32'h00005A5A);
        chk_iss("t4_r", base + 1, 16'h3FFF, 2'b11, 1'b0);
        chk("t4_rd", {24'd0, rd_data}, 32'hC3);
        rom_cs = 0; ram_cs = 0; ram_we = 0;
        @(negedge clk);

        // 5: Microdisk ROM
        base = n_iss; port_q = 16'h1357;
        rom_ext_cs = 1; rom_addr = 14'h1FFE;
        @(negedge clk);
        wait_idle("t5");
        chk_iss("t5", base, 16'h4FFF, 2'b11, 1'b0);
        chk("t5_rd", {24'd0, rd_data}, 32'h57);
        rom_ext_cs = 0;
        @(negedge clk);

        // ROM beats a simultaneous RAM read
        base = n_iss; port_q = 16'hA1B2;
        rom_cs = 1; rom_sel = 0; rom_addr = 14'h0003;
        ram_cs = 1; ram_oe = 1; ram_addr = 16'h0100;
        @(negedge clk);
        wait_idle("pr");
        chk("pr_niss", n_iss - base, 2);
        chk("pr_a0", {16'd0, iss_a[base]}, 32'h0001);
        chk("pr_a1", {16'd0, iss_a[base + 1]}, 32'h8080);
        chk("pr_rd", {24'd0, rd_data}, 32'hB2);
        rom_cs = 0; ram_cs = 0; ram_oe = 0;
        @(negedge clk);

`ifdef ORIC_SCHED_TMO_EN
        // 6: ack never returns, timeout after 64 WAIT cycles
        ack_hold = 1; port_q = 16'h6677;
        ram_cs = 1; ram_oe = 1; ram_addr = 16'h0002;
        repeat (66) @(negedge clk);
        chk("t6_pre", {31'd0, tmo_err}, 0);
        @(negedge clk);
        chk("t6_tmo", {31'd0, tmo_err}, 1);
        chk("t6_busy", {31'd0, busy}, 0);
        chk("t6_sync", {31'd0, port_req ^ port_ack}, 0);
        chk("t6_rd", {24'd0, rd_data}, 32'hB2);
        ram_cs = 0; ram_oe = 0; ack_hold = 0;
        @(negedge clk);
        ram_cs = 1; ram_oe = 1; ram_addr = 16'h0005;
        @(negedge clk);
        wait_idle("t6n");
        chk("t6n_a", {16'd0, port_a}, 32'h8002);
        chk("t6n_rd", {24'd0, rd_data}, 32'h66);
        ram_cs = 0; ram_oe = 0;
`else
        chk("t6_tmo_off", {31'd0, tmo_err}, 0);
`endif
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
